// File: rtl/wide_add_seq_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_seq_pkg
// Shared definitions for the slice-serial wide adder: FSM state encoding and
// the width of one adder slice.
// -----------------------------------------------------------------------------
package wide_add_seq_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : wide_add_seq_pkg

// File: rtl/wide_add_seq_cla.sv
// -----------------------------------------------------------------------------
// cla_16
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups with a
// second lookahead level across the groups.
//
// Ports
//   a_i, b_i : 16-bit addends
//   c_i      : carry in
//   s_o      : 16-bit sum
//   c_o      : carry out of bit 15
// -----------------------------------------------------------------------------
module cla_16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] s_o,
   output logic        c_o
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [4:0]  gc;

   always_comb begin
      g  = a_i & b_i;
      p  = a_i ^ b_i;
      gg = '0;
      gp = '0;
      c  = '0;

      // Group generate/propagate for each nibble.
      for (int j = 0; j < 4; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end

      // Second-level lookahead: carry into each nibble from c_i directly.
      gc[0] = c_i;
      gc[1] = gg[0] | (gp[0] & c_i);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & c_i);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);

      // Bit carries inside each nibble, seeded by the group carry.
      for (int j = 0; j < 4; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j]   | (p[4*j]   & gc[j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])   | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
   end

   assign s_o = p ^ c;
   assign c_o = gc[4];

endmodule : cla_16

// File: rtl/wide_add_seq.sv
// -----------------------------------------------------------------------------
// wide_add_seq
// Slice-serial W-bit adder/subtractor (W = 16*SLICES). One request is
// captured, then a single shared 16-bit CLA processes one slice per cycle,
// LSB slice first, and the result is held until the consumer accepts it.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : request valid          in_ready  : block idle, accepts request
//   a, b      : W-bit operands         cin       : carry in (add mode only)
//   sub       : 1 = a - b
//   out_valid : result valid           out_ready : consumer accepts result
//   sum       : W-bit result           cout      : carry out (1 = no borrow)
//   ovf       : two's-complement signed overflow
// -----------------------------------------------------------------------------
module wide_add_seq
   import wide_add_seq_pkg::*;
#(
   parameter int SLICES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SLICE_W*SLICES-1:0] a,
   input  logic [SLICE_W*SLICES-1:0] b,
   input  logic                      cin,
   input  logic                      sub,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SLICE_W*SLICES-1:0] sum,
   output logic                      cout,
   output logic                      ovf
);

   localparam int CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;

   state_e                          state_q;
   logic [CNT_W-1:0]                cnt_q;
   logic [CNT_W-1:0]                cnt_d;
   logic [SLICES-1:0][SLICE_W-1:0]  a_q;
   logic [SLICES-1:0][SLICE_W-1:0]  b_q;
   logic [SLICES-1:0][SLICE_W-1:0]  sum_q;
   logic                            carry_q;
   logic                            cout_q;
   logic                            ovf_q;

   logic [SLICE_W-1:0]              a_sl;
   logic [SLICE_W-1:0]              b_sl;
   logic [SLICE_W-1:0]              s_sl;
   logic                            c_sl;
   logic                            last_slice;

   // Operand slice selection: plain mux on the slice counter.
   assign a_sl       = a_q[cnt_q];
   assign b_sl       = b_q[cnt_q];
   assign cnt_d      = cnt_q + CNT_W'(1);
   assign last_slice = (cnt_q == CNT_W'(SLICES-1));

   cla_16 u_cla (
      .a_i (a_sl),
      .b_i (b_sl),
      .c_i (carry_q),
      .s_o (s_sl),
      .c_o (c_sl)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1; cin is ignored in that mode.
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  cnt_q   <= '0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               sum_q[cnt_q] <= s_sl;
               carry_q      <= c_sl;
               if (last_slice) begin
                  cout_q  <= c_sl;
                  // Top-slice result is not yet in sum_q, so use s_sl directly.
                  ovf_q   <= (a_q[SLICES-1][SLICE_W-1] == b_q[SLICES-1][SLICE_W-1])
                           & (s_sl[SLICE_W-1] != a_q[SLICES-1][SLICE_W-1]);
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule : wide_add_seq

// File: tb/tb_wide_add_seq.sv
module tb_wide_add_seq;

   localparam int SLICES = 4;
   localparam int W      = 16*SLICES;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          op_cin;
   logic          op_sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;

   int checks = 0;
   int errors = 0;

   wide_add_seq #(.SLICES(SLICES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (op_a),
      .b         (op_b),
      .cin       (op_cin),
      .sub       (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the whole word.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic mcin, input logic msub,
                        output logic [W-1:0] es, output logic ec, output logic eo);
      logic [W:0]        u;
      logic signed [W:0] sa;
      logic signed [W:0] sb;
      logic signed [W:0] st;
      sa = $signed({ma[W-1], ma});
      sb = $signed({mb[W-1], mb});
      if (msub) begin
         es = ma - mb;
         ec = (ma >= mb);
         st = sa - sb;
      end else begin
         u  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
         es = u[W-1:0];
         ec = u[W];
         st = sa + sb;
         if (mcin) st = st + 1;
      end
      eo = (st[W] != st[W-1]);
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                         input logic tcin, input logic tsub, input bit early_rdy,
                         output logic [W-1:0] rs, output logic rc, output logic ro,
                         output int lat);
      int waitc;
      @(negedge clk);
      waitc = 0;
      while (!in_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      chk("in_ready_before_req", {63'd0, in_ready}, 64'd1);
      op_a      = ta;
      op_b      = tb_in;
      op_cin    = tcin;
      op_sub    = tsub;
      in_valid  = 1'b1;
      out_ready = early_rdy;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble inputs after capture; the result must not depend on them.
      op_a   = {$urandom, $urandom};
      op_b   = {$urandom, $urandom};
      op_cin = 1'($urandom);
      op_sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rs = sum;
      rc = cout;
      ro = ovf;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] rs, es, ra, rb;
      logic         rc, ro, ec, eo, rcin, rsub;
      int           lat;
      int           stale;

      vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{64'h7, 64'h7, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
      vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[7] = '{64'd10, 64'd3, 1'b0, 1'b1, 64'd7, 1'b1, 1'b0};
      vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_cin    = 1'b0;
      op_sub    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_sum",       sum,                64'd0);
      chk("rst_cout",      {63'd0, cout},      64'd0);
      chk("rst_ovf",       {63'd0, ovf},       64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, bit'(i % 2), rs, rc, ro, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(SLICES));
         chk($sformatf("vec%0d_sum", i),  rs,              vecs[i].sum);
         chk($sformatf("vec%0d_cout", i), {63'd0, rc},     {63'd0, vecs[i].cout});
         chk($sformatf("vec%0d_ovf", i),  {63'd0, ro},     {63'd0, vecs[i].ovf});
         chk($sformatf("vec%0d_sum_kept", i), sum,         vecs[i].sum);
         chk($sformatf("vec%0d_idle", i), {62'd0, out_valid, in_ready}, 64'd1);
      end

      // Backpressure: hold result for 10 cycles while a new request waits.
      @(negedge clk);
      op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h0FED_CBA9_8765_4321;
      op_cin = 1'b1; op_sub = 1'b0;
      model(op_a, op_b, op_cin, op_sub, es, ec, eo);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp_latency", 64'(lat), 64'(SLICES));
      @(negedge clk);
      ra = 64'hFFFF_0000_FFFF_0000; rb = 64'h0001_0001_0001_0001;
      op_a = ra; op_b = rb; op_cin = 1'b0; op_sub = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp_sum_hold",  sum, es);
         chk("bp_flags_hold", {62'd0, cout, ovf}, {62'd0, ec, eo});
         chk("bp_handshake", {62'd0, out_valid, in_ready}, 64'd2);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_release_idle", {62'd0, out_valid, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk("bp_second_accept", {62'd0, out_valid, in_ready}, 64'd0);
      in_valid = 1'b0;
      model(ra, rb, 1'b0, 1'b1, es, ec, eo);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp2_latency", 64'(lat), 64'(SLICES));
      chk("bp2_sum", sum, es);
      chk("bp2_flags", {62'd0, cout, ovf}, {62'd0, ec, eo});
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Reset asserted while slice 2 is being computed.
      @(negedge clk);
      op_a = 64'h1111_2222_3333_4444; op_b = 64'h0101_0101_0101_0101;
      op_cin = 1'b0; op_sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_sum",       sum,                64'd0);
      chk("midrst_cout_ovf",  {62'd0, cout, ovf}, 64'd0);
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) stale++;
      end
      chk("midrst_no_stale_valid", 64'(stale), 64'd0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         rcin = 1'($urandom);
         rsub = 1'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ~ra;
            1: ra = {1'b0, {(W-1){1'b1}}};
            default: ;
         endcase
         model(ra, rb, rcin, rsub, es, ec, eo);
         run_op(ra, rb, rcin, rsub, bit'($urandom_range(0, 1)), rs, rc, ro, lat);
         chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(SLICES));
         chk($sformatf("rnd%0d_sum", i), rs, es);
         chk($sformatf("rnd%0d_flags", i), {62'd0, rc, ro}, {62'd0, ec, eo});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_wide_add_seq
